// File: rtl/pc_gen_if.sv
// Fetch PC generator bus: stall/flush/redirect requests in, fetch PC and slot status out.
interface pc_gen_if #(
    parameter int unsigned ADDR_W    = 32,
    parameter int unsigned NUM_REDIR = 2
);
    logic                          en;
    logic                          flush;
    logic [ADDR_W-1:0]             flush_pc;
    logic [NUM_REDIR-1:0]          redir_valid;
    logic [NUM_REDIR*ADDR_W-1:0]   redir_target;
    logic [ADDR_W-1:0]             pc;
    logic                          pc_misaligned;
    logic                          pend_valid;
    logic                          redir_drop;

    modport master (
        output en, flush, flush_pc, redir_valid, redir_target,
        input  pc, pc_misaligned, pend_valid, redir_drop
    );

    modport slave (
        input  en, flush, flush_pc, redir_valid, redir_target,
        output pc, pc_misaligned, pend_valid, redir_drop
    );
endinterface

// File: rtl/pc_gen.sv
// Fetch program-counter generator: sequential advance, prioritised flush/redirect,
// and a one-entry pending redirect slot held across fetch stalls.
module pc_gen #(
    parameter int unsigned       ADDR_W      = 32,
    parameter logic [ADDR_W-1:0] RESET_PC    = ADDR_W'(32'hbfc00000),
    parameter int unsigned       FETCH_BYTES = 4,
    parameter int unsigned       NUM_REDIR   = 2
) (
    input  logic     clk,
    input  logic     rst,
    pc_gen_if.slave  bus
);
    localparam int unsigned SRC_W = (NUM_REDIR > 1) ? $clog2(NUM_REDIR) : 1;
    localparam int unsigned OFF_W = $clog2(FETCH_BYTES);

    logic [ADDR_W-1:0] pc_q, pc_d;
    logic              pend_valid_q, pend_valid_d;
    logic [ADDR_W-1:0] pend_target_q, pend_target_d;
    logic [SRC_W-1:0]  pend_src_q, pend_src_d;
    logic              redir_drop_q, redir_drop_d;

    logic [SRC_W-1:0]  sel;
    logic [ADDR_W-1:0] sel_target;
    logic              any_redir;
    logic              multi_redir;
    logic              found;

    // Lowest-index channel wins; more than one request means the rest are lost.
    always_comb begin
        sel        = '0;
        sel_target = '0;
        found      = 1'b0;
        for (int unsigned i = 0; i < NUM_REDIR; i++) begin
            if (bus.redir_valid[i] && !found) begin
                found      = 1'b1;
                sel        = SRC_W'(i);
                sel_target = bus.redir_target[i*ADDR_W +: ADDR_W];
            end
        end
        any_redir   = |bus.redir_valid;
        multi_redir = |(bus.redir_valid & (bus.redir_valid - NUM_REDIR'(1)));
    end

    always_comb begin
        pc_d          = pc_q;
        pend_valid_d  = pend_valid_q;
        pend_target_d = pend_target_q;
        pend_src_d    = pend_src_q;
        redir_drop_d  = 1'b0;

        if (bus.flush) begin
            pc_d         = bus.flush_pc;
            pend_valid_d = 1'b0;
        end else if (bus.en) begin
            if (pend_valid_q) begin
                pc_d         = pend_target_q;
                pend_valid_d = 1'b0;
                redir_drop_d = any_redir;
            end else if (any_redir) begin
                pc_d         = sel_target;
                redir_drop_d = multi_redir;
            end else begin
                pc_d = pc_q + ADDR_W'(FETCH_BYTES);
            end
        end else if (any_redir) begin
            // A replaced slot entry is superseded, not reported as a drop.
            if (!pend_valid_q || (sel < pend_src_q)) begin
                pend_valid_d  = 1'b1;
                pend_target_d = sel_target;
                pend_src_d    = sel;
                redir_drop_d  = multi_redir;
            end else begin
                redir_drop_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pc_q          <= RESET_PC;
            pend_valid_q  <= 1'b0;
            pend_target_q <= '0;
            pend_src_q    <= '0;
            redir_drop_q  <= 1'b0;
        end else begin
            pc_q          <= pc_d;
            pend_valid_q  <= pend_valid_d;
            pend_target_q <= pend_target_d;
            pend_src_q    <= pend_src_d;
            redir_drop_q  <= redir_drop_d;
        end
    end

    assign bus.pc            = pc_q;
    assign bus.pend_valid    = pend_valid_q;
    assign bus.redir_drop    = redir_drop_q;
    assign bus.pc_misaligned = |pc_q[OFF_W-1:0];
endmodule

// File: tb/tb_pc_gen.sv
// Directed self-checking bench for pc_gen (4-byte and 8-byte fetch widths).
module tb_pc_gen;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   vectors = 0;
    int   errors  = 0;

    always #5 clk = ~clk;

    pc_gen_if #(.ADDR_W(32), .NUM_REDIR(2)) bus  ();
    pc_gen_if #(.ADDR_W(32), .NUM_REDIR(2)) bus8 ();

    pc_gen #(.ADDR_W(32), .RESET_PC(32'hbfc00000), .FETCH_BYTES(4), .NUM_REDIR(2))
        dut (.clk(clk), .rst(rst), .bus(bus));

    pc_gen #(.ADDR_W(32), .RESET_PC(32'hbfc00000), .FETCH_BYTES(8), .NUM_REDIR(2))
        dut8 (.clk(clk), .rst(rst), .bus(bus8));

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_redir(input logic [1:0] v, input logic [31:0] t0, input logic [31:0] t1);
        bus.redir_valid  = v;
        bus.redir_target = {t1, t0};
    endtask

    task automatic test_reset();
        tick(); tick();
        rst = 1'b0;
        tick(); tick();
        // pc now bfc00008; park a redirect so reset has something to lose
        bus.en = 1'b0;
        set_redir(2'b01, 32'h00000500, 32'h0);
        tick();
        set_redir(2'b00, 32'h0, 32'h0);
        vectors++;
        if (bus.pend_valid !== 1'b1) begin errors++; $display("FAIL pre_reset_pend: got %b want 1", bus.pend_valid); end
        vectors++;
        if (bus.pc !== 32'hbfc00008) begin errors++; $display("FAIL pre_reset_pc: got %h want bfc00008", bus.pc); end
        rst = 1'b1;
        #1;
        vectors++;
        if (bus.pc !== 32'hbfc00000) begin errors++; $display("FAIL async_reset_pc: got %h want bfc00000", bus.pc); end
        vectors++;
        if (bus.pend_valid !== 1'b0) begin errors++; $display("FAIL async_reset_pend: got %b want 0", bus.pend_valid); end
        vectors++;
        if (bus.redir_drop !== 1'b0 || bus.pc_misaligned !== 1'b0) begin
            errors++; $display("FAIL async_reset_flags: got drop=%b mis=%b want 0 0", bus.redir_drop, bus.pc_misaligned);
        end
        vectors++;
        if (bus8.pc !== 32'hbfc00000) begin errors++; $display("FAIL reset_pc8: got %h want bfc00000", bus8.pc); end
        tick();
        rst = 1'b0;
        bus.en = 1'b1;
        for (int i = 1; i <= 3; i++) begin
            tick();
            vectors++;
            if (bus.pc !== 32'hbfc00000 + 32'(4*i)) begin
                errors++; $display("FAIL advance4_%0d: got %h want %h", i, bus.pc, 32'hbfc00000 + 32'(4*i));
            end
            vectors++;
            if (bus8.pc !== 32'hbfc00000 + 32'(8*i)) begin
                errors++; $display("FAIL advance8_%0d: got %h want %h", i, bus8.pc, 32'hbfc00000 + 32'(8*i));
            end
        end
        vectors++;
        if (bus.pend_valid !== 1'b0 || bus.redir_drop !== 1'b0) begin
            errors++; $display("FAIL reset_lost_pend: got pend=%b drop=%b want 0 0", bus.pend_valid, bus.redir_drop);
        end
    endtask

    task automatic test_stalled_capture();
        // pc = bfc0000c on entry
        bus.en = 1'b0;
        set_redir(2'b10, 32'h0, 32'h80001000);
        tick();
        set_redir(2'b00, 32'h0, 32'h0);
        vectors++;
        if (bus.pend_valid !== 1'b1 || bus.pc !== 32'hbfc0000c) begin
            errors++; $display("FAIL cap_hold: got pend=%b pc=%h want 1 bfc0000c", bus.pend_valid, bus.pc);
        end
        tick(); tick();
        vectors++;
        if (bus.pc !== 32'hbfc0000c) begin errors++; $display("FAIL cap_stall_pc: got %h want bfc0000c", bus.pc); end
        bus.en = 1'b1;
        tick();
        vectors++;
        if (bus.pc !== 32'h80001000 || bus.pend_valid !== 1'b0) begin
            errors++; $display("FAIL cap_apply: got pc=%h pend=%b want 80001000 0", bus.pc, bus.pend_valid);
        end
        tick();
        vectors++;
        if (bus.pc !== 32'h80001004) begin errors++; $display("FAIL cap_next: got %h want 80001004", bus.pc); end
    endtask

    task automatic test_stalled_arb();
        bus.en = 1'b0;
        set_redir(2'b10, 32'h0, 32'h00000100);
        tick();
        vectors++;
        if (bus.redir_drop !== 1'b0) begin errors++; $display("FAIL arb_drop1: got %b want 0", bus.redir_drop); end
        set_redir(2'b01, 32'h00000200, 32'h0);
        tick();
        vectors++;
        if (bus.redir_drop !== 1'b0) begin errors++; $display("FAIL arb_drop2: got %b want 0", bus.redir_drop); end
        set_redir(2'b10, 32'h0, 32'h00000300);
        tick();
        set_redir(2'b00, 32'h0, 32'h0);
        vectors++;
        if (bus.redir_drop !== 1'b1) begin errors++; $display("FAIL arb_drop3: got %b want 1", bus.redir_drop); end
        tick();
        vectors++;
        if (bus.redir_drop !== 1'b0 || bus.pc !== 32'h80001004) begin
            errors++; $display("FAIL arb_idle: got drop=%b pc=%h want 0 80001004", bus.redir_drop, bus.pc);
        end
        bus.en = 1'b1;
        tick();
        vectors++;
        if (bus.pc !== 32'h00000200) begin errors++; $display("FAIL arb_apply: got %h want 00000200", bus.pc); end
    endtask

    task automatic test_simultaneous();
        bus.en = 1'b1;
        set_redir(2'b11, 32'h00000400, 32'h00000500);
        tick();
        set_redir(2'b00, 32'h0, 32'h0);
        vectors++;
        if (bus.pc !== 32'h00000400 || bus.redir_drop !== 1'b1) begin
            errors++; $display("FAIL simul: got pc=%h drop=%b want 00000400 1", bus.pc, bus.redir_drop);
        end
        tick();
        vectors++;
        if (bus.pc !== 32'h00000404 || bus.redir_drop !== 1'b0) begin
            errors++; $display("FAIL simul_next: got pc=%h drop=%b want 00000404 0", bus.pc, bus.redir_drop);
        end
    endtask

    task automatic test_pend_vs_redir();
        bus.en = 1'b0;
        set_redir(2'b01, 32'h00000700, 32'h0);
        tick();
        bus.en = 1'b1;
        set_redir(2'b10, 32'h0, 32'h00000800);
        tick();
        set_redir(2'b00, 32'h0, 32'h0);
        vectors++;
        if (bus.pc !== 32'h00000700 || bus.redir_drop !== 1'b1 || bus.pend_valid !== 1'b0) begin
            errors++; $display("FAIL pend_wins: got pc=%h drop=%b pend=%b want 00000700 1 0", bus.pc, bus.redir_drop, bus.pend_valid);
        end
    endtask

    task automatic test_flush();
        bus.en = 1'b0;
        set_redir(2'b01, 32'h00000600, 32'h0);
        tick();
        bus.en       = 1'b1;
        bus.flush    = 1'b1;
        bus.flush_pc = 32'hbfc00380;
        set_redir(2'b01, 32'h00000999, 32'h0);
        tick();
        bus.flush = 1'b0;
        set_redir(2'b00, 32'h0, 32'h0);
        vectors++;
        if (bus.pc !== 32'hbfc00380 || bus.pend_valid !== 1'b0 || bus.redir_drop !== 1'b0) begin
            errors++; $display("FAIL flush: got pc=%h pend=%b drop=%b want bfc00380 0 0", bus.pc, bus.pend_valid, bus.redir_drop);
        end
        tick();
        vectors++;
        if (bus.pc !== 32'hbfc00384) begin errors++; $display("FAIL flush_next: got %h want bfc00384", bus.pc); end
    endtask

    task automatic test_wrap_misalign();
        bus.flush    = 1'b1;
        bus.flush_pc = 32'hfffffffc;
        tick();
        bus.flush = 1'b0;
        tick();
        vectors++;
        if (bus.pc !== 32'h00000000) begin errors++; $display("FAIL wrap: got %h want 00000000", bus.pc); end
        set_redir(2'b01, 32'h00001002, 32'h0);
        tick();
        set_redir(2'b00, 32'h0, 32'h0);
        vectors++;
        if (bus.pc !== 32'h00001002 || bus.pc_misaligned !== 1'b1) begin
            errors++; $display("FAIL misalign_set: got pc=%h mis=%b want 00001002 1", bus.pc, bus.pc_misaligned);
        end
        tick();
        vectors++;
        if (bus.pc !== 32'h00001006 || bus.pc_misaligned !== 1'b1) begin
            errors++; $display("FAIL misalign_hold: got pc=%h mis=%b want 00001006 1", bus.pc, bus.pc_misaligned);
        end
        set_redir(2'b10, 32'h0, 32'h00002000);
        tick();
        set_redir(2'b00, 32'h0, 32'h0);
        vectors++;
        if (bus.pc !== 32'h00002000 || bus.pc_misaligned !== 1'b0) begin
            errors++; $display("FAIL misalign_clr: got pc=%h mis=%b want 00002000 0", bus.pc, bus.pc_misaligned);
        end
    endtask

    initial begin
        bus.en            = 1'b1;
        bus.flush         = 1'b0;
        bus.flush_pc      = '0;
        bus.redir_valid   = '0;
        bus.redir_target  = '0;
        bus8.en           = 1'b1;
        bus8.flush        = 1'b0;
        bus8.flush_pc     = '0;
        bus8.redir_valid  = '0;
        bus8.redir_target = '0;
        test_reset();
        test_stalled_capture();
        test_stalled_arb();
        test_simultaneous();
        test_pend_vs_redir();
        test_flush();
        test_wrap_misalign();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end
endmodule
